// File: rtl/button_conditioner.sv
// Five-channel push-button conditioner: 2-flop sync, debounce, press strobe.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat pulses per channel.

module button_lane #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {IDLE, PRESSED, HOLD_WAIT, REPEAT} state_t;

    logic          sync1, sync2, diff_q;
    logic [CW-1:0] cnt;
    logic          mismatch, toggle, rise, fall;
    state_t        state_q, state_d;
    logic          pulse_d;

    assign mismatch = sync2 ^ level;
    // diff_q makes a change qualify only after two consecutive mismatch samples
    assign toggle   = diff_q & mismatch & (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign rise     = toggle & ~level;
    assign fall     = toggle & level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            diff_q <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (toggle) begin
                level  <= ~level;
                cnt    <= '0;
                diff_q <= 1'b0;
            end else begin
                diff_q <= mismatch;
                if (diff_q && mismatch) cnt <= cnt + 1'b1;
                else                    cnt <= '0;
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(TMAX + 1);

    logic [TW-1:0] tmr_q, tmr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmr_q <= '0;
        else        tmr_q <= tmr_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        pulse_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        tmr_d   = tmr_q + 1'b1;
`endif
        case (state_q)
            IDLE: begin
`ifdef BTN_AUTOREPEAT_EN
                tmr_d = '0;
`endif
                if (rise) begin
                    state_d = PRESSED;
                    pulse_d = 1'b1;
                end
            end
            PRESSED: state_d = HOLD_WAIT;
            HOLD_WAIT: begin
                if (fall) state_d = IDLE;
`ifdef BTN_AUTOREPEAT_EN
                else if (tmr_q == TW'(REPEAT_DELAY - 1)) begin
                    state_d = REPEAT;
                    pulse_d = 1'b1;
                    tmr_d   = '0;
                end
`endif
            end
            REPEAT: begin
                if (fall) state_d = IDLE;
`ifdef BTN_AUTOREPEAT_EN
                else if (tmr_q == TW'(REPEAT_PERIOD - 1)) begin
                    pulse_d = 1'b1;
                    tmr_d   = '0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pulse   <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse   <= pulse_d;
        end
    end
endmodule

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_pulse
);
    localparam int NUM_LANES = 5;

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_cfg_check
        $error("button_conditioner: illegal timing parameters");
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        button_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn_raw[g]),
            .level(btn_level[g]),
            .pulse(btn_pulse[g])
        );
    end
endmodule

// File: tb/tb_button_conditioner.sv
// Directed + random bench for button_conditioner against a behavioural model:
// a level flips after DEBOUNCE_CYCLES+1 consecutive disagreeing synced samples.
module tb_button_conditioner;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btn_raw = '0;
    logic [4:0] btn_level, btn_pulse;

    int n_assert = 0;
    int n_fail   = 0;

    logic [4:0] m_s1, m_s2, m_lvl, m_pulse;
    int run [5];
    int hold[5];
    int left[5];
    int pcount;

    button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0;
        for (int i = 0; i < 5; i++) begin
            run[i]  = 0;
            hold[i] = 0;
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_clear();
            return;
        end
        for (int i = 0; i < 5; i++) begin
            m_pulse[i] = 1'b0;
            if (m_s2[i] != m_lvl[i]) run[i]++;
            else                     run[i] = 0;
            if (run[i] == D + 1) begin
                m_lvl[i] = ~m_lvl[i];
                run[i]   = 0;
                if (m_lvl[i]) begin
                    m_pulse[i] = 1'b1;
                    hold[i]    = 0;
                end
            end else if (m_lvl[i]) begin
                hold[i]++;
`ifdef BTN_AUTOREPEAT_EN
                if (hold[i] == RD || (hold[i] > RD && (hold[i] - RD) % RP == 0))
                    m_pulse[i] = 1'b1;
`endif
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = btn_raw[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_level", btn_level, m_lvl);
        chk("model_pulse", btn_pulse, m_pulse);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        model_clear();
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_level", btn_level, 5'b00000);
        chk("reset_pulse", btn_pulse, 5'b00000);
        rst_n = 1'b1;
        ticks(3);

        // clean press on channel 0: edges 0..5 quiet, level+pulse after edge 6
        btn_raw = 5'b00001;
        ticks(6);
        chk("press_early", btn_level, 5'b00000);
        tick();
        chk("press_level", btn_level, 5'b00001);
        chk("press_pulse", btn_pulse, 5'b00001);
        tick();
        chk("press_pulse_end", btn_pulse, 5'b00000);
        btn_raw = 5'b00000;
        ticks(10);
        chk("release_level", btn_level, 5'b00000);

        // bounce on channel 1
        for (int r = 0; r < 4; r++) begin
            btn_raw[1] = 1'b1; tick();
            btn_raw[1] = 1'b1; tick();
            btn_raw[1] = 1'b1; tick();
            btn_raw[1] = 1'b0; tick();
        end
        chk("bounce_level", btn_level, 5'b00000);
        btn_raw[1] = 1'b1;
        ticks(6);
        chk("bounce_early", btn_level, 5'b00000);
        tick();
        chk("bounce_level_up", btn_level, 5'b00010);
        chk("bounce_pulse", btn_pulse, 5'b00010);
        btn_raw = 5'b00000;
        ticks(10);

        // simultaneous presses
        btn_raw = 5'b10101;
        ticks(6);
        tick();
        chk("simul_pulse", btn_pulse, 5'b10101);
        tick();
        chk("simul_pulse_end", btn_pulse, 5'b00000);
        btn_raw = 5'b00000;
        ticks(10);

        // reset mid-count on channel 3, held through release
        btn_raw = 5'b01000;
        ticks(4);
        rst_n = 1'b0;
        #1;
        chk("midrst_level", btn_level, 5'b00000);
        chk("midrst_pulse", btn_pulse, 5'b00000);
        model_clear();
        ticks(2);
        rst_n = 1'b1;
        pcount = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (btn_pulse[3]) pcount++;
        end
        chk("midrst_early", btn_level, 5'b00000);
        tick();
        chk("midrst_level_up", btn_level, 5'b01000);
        chk("midrst_pulse_up", btn_pulse, 5'b01000);
        if (btn_pulse[3]) pcount++;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (btn_pulse[3]) pcount++;
        end
        chk_int("midrst_pulse_count", pcount, 1);
        btn_raw = 5'b00000;
        ticks(10);

        // hold channel 2 for 40 cycles
        btn_raw = 5'b00100;
        pcount = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (btn_pulse[2]) pcount++;
        end
        btn_raw = 5'b00000;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (btn_pulse[2]) pcount++;
        end
`ifdef BTN_AUTOREPEAT_EN
        chk_int("hold_pulse_count", pcount, 11);
`else
        chk_int("hold_pulse_count", pcount, 1);
`endif
        chk("hold_release_level", btn_level, 5'b00000);

        // random run lengths, mixing bounce with accepted presses and long holds
        for (int i = 0; i < 5; i++) left[i] = $urandom_range(1, 14);
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 5; i++) begin
                if (left[i] == 0) begin
                    btn_raw[i] = ~btn_raw[i];
                    left[i] = ($urandom_range(0, 7) == 0) ? 40 : $urandom_range(1, 14);
                end
                left[i]--;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have one clock and one reset: the reset SHALL be asynchronous and active-low.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the consecutive stable cycles needed to accept a change (10 ms at 100 MHz); legal range 2..2^24.
REQ-003 Parameter REPEAT_DELAY, default 50000000, SHALL set the cycles from a press pulse to the first repeat pulse.
REQ-004 Parameter REPEAT_PERIOD, default 10000000, SHALL set the cycles between later repeat pulses.
REQ-005 Port clk, input, 1 bit, SHALL be the system clock; all flops use its rising edge.
REQ-006 Port rst_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-007 Port btn_raw, input, 5 bits, SHALL carry the raw asynchronous push-buttons; bit i is channel i, and 1 means pressed.
REQ-008 Port btn_level, output, 5 bits, SHALL carry the debounced registered button levels.
REQ-009 Port btn_pulse, output, 5 bits, SHALL carry registered one-cycle press strobes that feed the manual-mode controller's button inputs.

Function
REQ-010 Each channel SHALL be processed independently by identical logic; pulses on several channels in the same cycle SHALL be allowed.
REQ-011 Each btn_raw bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-012 Each channel SHALL keep a counter of width clog2(DEBOUNCE_CYCLES): it increments while sync2 differs from btn_level and clears to 0 while they match.
REQ-013 The channel's btn_level SHALL toggle, and its counter SHALL clear, on the edge where the counter equals DEBOUNCE_CYCLES-1 and the mismatch still holds.
REQ-014 Latency: a clean raw change SHALL reach btn_level exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it.
REQ-015 Bounce: a mismatch lasting fewer than DEBOUNCE_CYCLES consecutive cycles SHALL leave btn_level unchanged and SHALL restart the count from 0.
REQ-016 btn_pulse[i] SHALL be 1 for exactly the single cycle in which btn_level[i] first reads 1 after reading 0.
REQ-017 A 1-to-0 transition of btn_level SHALL produce no pulse.
REQ-018 Each channel FSM SHALL have states IDLE, PRESSED, HOLD_WAIT and REPEAT.
  - IDLE goes to PRESSED on a 0-to-1 level transition.
  - PRESSED goes to HOLD_WAIT after one cycle.
  - HOLD_WAIT and REPEAT go to IDLE on a level transition to 0.
  - HOLD_WAIT goes to REPEAT only when the REQ-026 macro is defined.
REQ-019 The FSM SHALL have no other transitions, and unused encodings SHALL return to IDLE on the next cycle.
REQ-020 The block SHALL contain no combinational path from btn_raw to any output.

Reset
REQ-021 While rst_n=0, sync1, sync2, counters, repeat timers, btn_level and btn_pulse SHALL all be 0, and the FSM SHALL be IDLE.
REQ-022 Assertion of rst_n mid-debounce or mid-hold SHALL discard the count immediately, with no pulse emitted.
REQ-023 A button held through reset release SHALL be treated as a new press: btn_level rises DEBOUNCE_CYCLES+2 edges after release, with one pulse.
REQ-024 rst_n SHALL be externally deasserted synchronously to clk; the block SHALL contain no internal reset synchronizer.

Configuration
REQ-025 With macro BTN_AUTOREPEAT_EN undefined, the block SHALL emit exactly one pulse per accepted press, HOLD_WAIT SHALL be terminal until release, and no repeat timer SHALL be synthesized.
REQ-026 With BTN_AUTOREPEAT_EN defined, autorepeat SHALL operate while btn_level stays 1:
  - The first repeat pulse follows the press pulse by exactly REPEAT_DELAY cycles.
  - Each later repeat pulse follows the previous one by exactly REPEAT_PERIOD cycles.
  - Each repeat pulse is one cycle wide.
REQ-027 Release SHALL stop repeats with no pulse on the release cycle.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-028 Clean press: btn_raw[0]=1 sampled at edge 0 -> btn_level[0]=1 and btn_pulse[0]=1 after edge 6; btn_pulse[0]=0 after edge 7.
REQ-029 Bounce: btn_raw[1] toggles 1,1,1,0 repeatedly, then holds 1 -> no level change during the toggling; level rises 6 edges after the final stable 1 is first sampled, with a single pulse.
REQ-030 Simultaneous: btn_raw=5'b10101 applied in one cycle -> btn_pulse=5'b10101 for one cycle, 6 edges later.
REQ-031 Reset mid-count: rst_n=0 at edge 4 of a press -> all outputs 0; after release with btn_raw held -> exactly one pulse 6 edges later.
REQ-032 Autorepeat (macro defined): hold btn_raw[2] for 40 cycles -> pulses at cycles P, P+10, P+13, P+16, ... until release; macro undefined -> single pulse at P only.
